// File: rtl/vga_timing_gen_if.sv
// vga_if: raster bundle passed down the draw pipeline (timing source -> background -> sprites -> overlays).
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing source (default 1024x768@60) feeding vga_if.
// Define VGA_TIMING_SOF_EN to add the frame_start pulse and frame_cnt counter ports.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  vga_if.out          vga_out
`ifdef VGA_TIMING_SOF_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_size_check
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
  end

  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX  = 11'(V_TOTAL - 1);
  // 12-bit bounds so an end-of-window equal to 2048 still compares correctly
  localparam logic [11:0] HB_ON  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VB_ON  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount, vcount, h_nxt, v_nxt;
  logic        hsync, vsync, hblnk, vblnk;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_wrap = (hcount == H_MAX);
    v_wrap = (vcount == V_MAX);
    h_nxt  = h_wrap ? 11'd0 : hcount + 11'd1;
    v_nxt  = vcount;
    if (h_wrap) v_nxt = v_wrap ? 11'd0 : vcount + 11'd1;
  end

  // Flags are decoded from the next counts so counts and flags land in the same register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
      hblnk  <= 1'b0;
      vblnk  <= 1'b0;
      hsync  <= ~SYNC_POL;
      vsync  <= ~SYNC_POL;
    end else if (en) begin
      hcount <= h_nxt;
      vcount <= v_nxt;
      hblnk  <= ({1'b0, h_nxt} >= HB_ON);
      vblnk  <= ({1'b0, v_nxt} >= VB_ON);
      hsync  <= (({1'b0, h_nxt} >= HS_ON) && ({1'b0, h_nxt} < HS_OFF)) ? SYNC_POL : ~SYNC_POL;
      vsync  <= (({1'b0, v_nxt} >= VS_ON) && ({1'b0, v_nxt} < VS_OFF)) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga_out.hcount = hcount;
  assign vga_out.vcount = vcount;
  assign vga_out.hsync  = hsync;
  assign vga_out.vsync  = vsync;
  assign vga_out.hblnk  = hblnk;
  assign vga_out.vblnk  = vblnk;
  assign vga_out.rgb    = 12'h000;

`ifdef VGA_TIMING_SOF_EN
  logic sof;
  assign sof = en && h_wrap && v_wrap;

  // Only a wrap into (0,0) counts as a frame start; reset does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= sof;
      if (sof) frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line/enable/reset behaviour, a shrunken
// active-low-sync instance for frame wrap and vertical timing.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a, en_a, rst_b, en_b;
  int   n_chk  = 0;
  int   n_fail = 0;

  vga_if va();
  vga_if vb();

`ifdef VGA_TIMING_SOF_EN
  logic        fs_a, fs_b;
  logic [15:0] fc_a, fc_b;
  vga_timing_gen u_a (.clk(clk), .rst(rst_a), .en(en_a), .vga_out(va),
                      .frame_start(fs_a), .frame_cnt(fc_a));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0))
    u_b (.clk(clk), .rst(rst_b), .en(en_b), .vga_out(vb),
         .frame_start(fs_b), .frame_cnt(fc_b));
`else
  vga_timing_gen u_a (.clk(clk), .rst(rst_a), .en(en_a), .vga_out(va));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0))
    u_b (.clk(clk), .rst(rst_b), .en(en_b), .vga_out(vb));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int eh, ev, prev_h, errs, hs_cnt, hs_first, hs_last, hb_first, wrap_ok;
    int last_wrap, period, ph, ps, pb, guard, frames, vs_low, hs_low;
    logic applied;

    rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;
    repeat (3) tick();
    chk("rst_h",     va.hcount, 0);
    chk("rst_v",     va.vcount, 0);
    chk("rst_hblnk", va.hblnk,  0);
    chk("rst_vblnk", va.vblnk,  0);
    chk("rst_hsync", va.hsync,  0);
    chk("rst_vsync", va.vsync,  0);
    chk("rst_rgb",   va.rgb,    0);
    chk("rstb_hsync", vb.hsync, 1);
    chk("rstb_vsync", vb.vsync, 1);

    rst_a = 1'b0;
    tick();
    chk("first_h", va.hcount, 1);
    chk("first_v", va.vcount, 0);

    // two full lines from (1,0)
    eh = 1; ev = 0; prev_h = 1; errs = 0; hs_cnt = 0;
    hs_first = -1; hs_last = -1; hb_first = -1; wrap_ok = 0;
    for (int c = 0; c < 2 * 1344; c++) begin
      tick();
      eh = (eh == 1343) ? 0 : eh + 1;
      if (eh == 0) ev++;
      if (va.hcount != eh || va.vcount != ev || va.rgb != 0 || va.vblnk || va.vsync) errs++;
      if (va.hblnk !== (eh >= 1024)) errs++;
      if (va.hsync !== (eh >= 1048 && eh < 1184)) errs++;
      if (ev == 0) begin
        if (va.hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(va.hcount);
          hs_last = int'(va.hcount);
        end
        if (va.hblnk && hb_first < 0) hb_first = int'(va.hcount);
      end
      if (prev_h == 1343 && va.hcount == 0 && va.vcount == 1) wrap_ok = 1;
      prev_h = int'(va.hcount);
    end
    chk("line_err",   errs,     0);
    chk("hsync_len",  hs_cnt,   136);
    chk("hsync_from", hs_first, 1048);
    chk("hsync_to",   hs_last,  1183);
    chk("hblnk_from", hb_first, 1024);
    chk("line_wrap",  wrap_ok,  1);

    // en toggling: half rate, outputs frozen on en=0 edges
    errs = 0; last_wrap = -1; period = -1;
    ph = int'(va.hcount); ps = va.hsync; pb = va.hblnk;
    for (int c = 0; c < 6000; c++) begin
      en_a = (c % 2 == 1);
      applied = en_a;
      tick();
      if (applied) begin
        eh = (eh == 1343) ? 0 : eh + 1;
        if (eh == 0) ev++;
      end
      if (va.hcount != eh || va.vcount != ev) errs++;
      if (!applied && (va.hsync !== ps[0] || va.hblnk !== pb[0])) errs++;
      if (va.hcount == 0 && ph != 0) begin
        if (last_wrap >= 0 && period < 0) period = c - last_wrap;
        last_wrap = c;
      end
      ph = int'(va.hcount); ps = va.hsync; pb = va.hblnk;
    end
    chk("tog_err",    errs,   0);
    chk("tog_period", period, 2688);

    // reset inside active area, with en=0 to show rst wins
    en_a = 1'b1; guard = 0;
    while (va.hcount != 500 && guard < 2000) begin tick(); guard++; end
    chk("reach_500", va.hcount, 500);
    chk("mid_vact",  va.vcount, 4);
    rst_a = 1'b1; en_a = 1'b0;
    tick();
    chk("rstmid_h", va.hcount, 0);
    chk("rstmid_v", va.vcount, 0);
    chk("rstmid_hblnk", va.hblnk, 0);

    // reset inside the hsync window drops the pulse
    rst_a = 1'b0; en_a = 1'b1; guard = 0;
    while (va.hcount != 1100 && guard < 2000) begin tick(); guard++; end
    chk("in_hsync", va.hsync, 1);
    rst_a = 1'b1;
    tick();
    chk("rstsync_h",     va.hcount, 0);
    chk("rstsync_hsync", va.hsync,  0);
    chk("rstsync_hblnk", va.hblnk,  0);
    rst_a = 1'b0;
    tick();
    chk("rerel_h", va.hcount, 1);

    // small instance: 16x11 raster, active-low syncs
    rst_b = 1'b0;
    tick();
    chk("b_first_h", vb.hcount, 1);
    eh = 1; ev = 0; errs = 0; frames = 0; vs_low = 0; hs_low = 0;
    for (int c = 0; c < 2 * 176; c++) begin
      tick();
      eh = (eh == 15) ? 0 : eh + 1;
      if (eh == 0) ev = (ev == 10) ? 0 : ev + 1;
      if (eh == 0 && ev == 0) frames++;
      if (vb.hcount != eh || vb.vcount != ev || vb.rgb != 0) errs++;
      if (vb.hblnk !== (eh >= 8) || vb.vblnk !== (ev >= 6)) errs++;
      if (vb.hsync !== !(eh >= 10 && eh < 13)) errs++;
      if (vb.vsync !== !(ev >= 7 && ev < 9)) errs++;
`ifdef VGA_TIMING_SOF_EN
      if (fs_b !== (eh == 0 && ev == 0)) errs++;
`endif
      if (c < 176) begin
        if (!vb.vsync) vs_low++;
        if (!vb.hsync) hs_low++;
      end
    end
    chk("b_frame_err", errs,   0);
    chk("b_frames",    frames, 2);
    chk("b_vs_low",    vs_low, 32);
    chk("b_hs_low",    hs_low, 33);
`ifdef VGA_TIMING_SOF_EN
    chk("b_frame_cnt", fc_b, 2);
    force u_b.frame_cnt = 16'hFFFF;
    tick();
    release u_b.frame_cnt;
    guard = 0;
    while (!fs_b && guard < 400) begin tick(); guard++; end
    chk("b_sof_seen", fs_b, 1);
    chk("b_cnt_wrap", fc_b, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
